// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, UART bus write channel and arbiter status, bundled for uart_tx_arbiter.
// master: arbiter side. slave: requesters, UART bus and status observers.
interface uart_tx_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [7:0]  req0_data;
   logic        req0_last;
   logic        req1_valid;
   logic        req1_ready;
   logic [7:0]  req1_data;
   logic        req1_last;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [1:0]  grant;
   logic        busy;

   modport master (
      input  req0_valid, req0_data, req0_last,
      input  req1_valid, req1_data, req1_last,
      input  m_ready,
      output req0_ready, req1_ready,
      output m_valid, m_wstrb, m_addr, m_wdata,
      output grant, busy
   );

   modport slave (
      output req0_valid, req0_data, req0_last,
      output req1_valid, req1_data, req1_last,
      output m_ready,
      input  req0_ready, req1_ready,
      input  m_valid, m_wstrb, m_addr, m_wdata,
      input  grant, busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding two byte streams into UART data-register writes; programs the divider after reset.
// Latency: byte accepted in IDLE, bus write issued next cycle; at most one byte per 2 cycles.
// Backpressure: m_ready low stalls in WRITE with req*_ready low. Optional lock timeout: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter logic [31:0] CLK_DIV   = 32'd104,
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000
`ifdef UART_TX_ARB_TIMEOUT_EN
   ,
   parameter logic [15:0] LOCK_TIMEOUT = 16'd1000
`endif
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_arbiter_if.master  bus
);

   typedef enum logic [1:0] {
      ST_CFG   = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        m_valid_q, m_valid_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic [3:0]  m_wstrb_q, m_wstrb_d;
   logic [1:0]  grant_q, grant_d;
   logic        lock_q, lock_d;
   logic        rr_ptr_q, rr_ptr_d;
   logic        last_q, last_d;

   logic        owner;
   logic        cand;
   logic        cand_vld;
   logic [7:0]  cand_data;
   logic        cand_last;
   logic        accept;
   logic        timeout_hit;

   // grant is one-hot, so bit 1 alone names the owner while locked
   assign owner = grant_q[1];

   always_comb begin
      cand = 1'b0;
      if (lock_q)
         cand = owner;
      else if (bus.req0_valid && bus.req1_valid)
         cand = rr_ptr_q;
      else
         cand = bus.req1_valid;
      cand_vld  = cand ? bus.req1_valid : bus.req0_valid;
      cand_data = cand ? bus.req1_data  : bus.req0_data;
      cand_last = cand ? bus.req1_last  : bus.req0_last;
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   logic [15:0] lock_cnt_q, lock_cnt_d;

   assign timeout_hit = (state_q == ST_IDLE) && lock_q && (lock_cnt_q == LOCK_TIMEOUT);

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (accept || timeout_hit)
         lock_cnt_d = 16'd0;
      else if ((state_q == ST_IDLE) && lock_q && !cand_vld)
         lock_cnt_d = lock_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         lock_cnt_q <= 16'd0;
      else
         lock_cnt_q <= lock_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // the release cycle of a timed-out lock accepts nothing
   assign accept         = (state_q == ST_IDLE) && cand_vld && !timeout_hit;
   assign bus.req0_ready = accept && !cand;
   assign bus.req1_ready = accept && cand;

   always_comb begin
      state_d   = state_q;
      m_valid_d = m_valid_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;
      grant_d   = grant_q;
      lock_d    = lock_q;
      rr_ptr_d  = rr_ptr_q;
      last_d    = last_q;
      case (state_q)
         ST_CFG: begin
            if (!m_valid_q) begin
               m_valid_d = 1'b1;
               m_addr_d  = BASE_ADDR;
               m_wstrb_d = 4'hF;
               m_wdata_d = CLK_DIV;
            end else if (bus.m_ready) begin
               m_valid_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (timeout_hit) begin
               lock_d   = 1'b0;
               grant_d  = 2'b00;
               rr_ptr_d = ~owner;
            end else if (accept) begin
               last_d    = cand_last;
               grant_d   = cand ? 2'b10 : 2'b01;
               lock_d    = !cand_last;
               m_valid_d = 1'b1;
               m_addr_d  = BASE_ADDR + 32'd4;
               m_wstrb_d = 4'b0001;
               m_wdata_d = {24'h0, cand_data};
               state_d   = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (m_valid_q && bus.m_ready) begin
               m_valid_d = 1'b0;
               state_d   = ST_IDLE;
               if (last_q) begin
                  lock_d   = 1'b0;
                  grant_d  = 2'b00;
                  rr_ptr_d = ~owner;
               end
            end
         end
         default: state_d = ST_CFG;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_CFG;
         m_valid_q <= 1'b0;
         m_addr_q  <= 32'h0;
         m_wdata_q <= 32'h0;
         m_wstrb_q <= 4'h0;
         grant_q   <= 2'b00;
         lock_q    <= 1'b0;
         rr_ptr_q  <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
         grant_q   <= grant_d;
         lock_q    <= lock_d;
         rr_ptr_q  <= rr_ptr_d;
         last_q    <= last_d;
      end
   end

   assign bus.m_valid = m_valid_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.m_wstrb = m_wstrb_q;
   assign bus.grant   = grant_q;
   assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: divider programming, locked packets, round-robin, mid-write reset, lock timeout.
// Requesters driven after posedge, bus slave and observation on negedge.
module tb_uart_tx_arbiter;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_tx_arbiter_if bif ();

`ifdef UART_TX_ARB_TIMEOUT_EN
   uart_tx_arbiter #(.CLK_DIV(32'd104), .BASE_ADDR(BASE), .LOCK_TIMEOUT(16'd8)) dut (
      .clk(clk), .reset(reset), .bus(bif.master));
`else
   uart_tx_arbiter #(.CLK_DIV(32'd104), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .bus(bif.master));
`endif

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // requester byte queues, entries are {last, data}
   logic [8:0]  q0[$];
   logic [8:0]  q1[$];
   logic        acc0 = 1'b0;
   logic        acc1 = 1'b0;

   // completed bus writes as seen by the slave
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [3:0]  wr_strb[$];
   logic [1:0]  wr_grant[$];

   int wait_cycles = 0;
   logic rsp_hold  = 1'b0;
   int rdy0_cnt = 0;
   int rdy1_cnt = 0;
   int first_r1 = -1;
   int stab_err = 0;
   int gap_err  = 0;
   int both_err = 0;

   initial begin
      bif.req0_valid = 1'b0; bif.req0_data = 8'h0; bif.req0_last = 1'b0;
      bif.req1_valid = 1'b0; bif.req1_data = 8'h0; bif.req1_last = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (acc0) begin void'(q0.pop_front()); acc0 = 1'b0; end
         if (acc1) begin void'(q1.pop_front()); acc1 = 1'b0; end
         bif.req0_valid = (q0.size() > 0);
         if (q0.size() > 0) begin bif.req0_data = q0[0][7:0]; bif.req0_last = q0[0][8]; end
         bif.req1_valid = (q1.size() > 0);
         if (q1.size() > 0) begin bif.req1_data = q1[0][7:0]; bif.req1_last = q1[0][8]; end
      end
   end

   // bus slave plus protocol observation
   initial begin
      int wcnt;
      logic prev_pend, prev_hs;
      logic [31:0] sv_addr, sv_data;
      logic [3:0]  sv_strb;
      wcnt = 0; prev_pend = 1'b0; prev_hs = 1'b0;
      sv_addr = '0; sv_data = '0; sv_strb = '0;
      bif.m_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_pend && bif.m_valid &&
             (bif.m_addr !== sv_addr || bif.m_wdata !== sv_data || bif.m_wstrb !== sv_strb))
            stab_err++;
         if (prev_hs && bif.m_valid) gap_err++;
         if (bif.req0_ready && bif.req1_ready) both_err++;
         if (bif.req0_ready) begin rdy0_cnt++; acc0 = 1'b1; end
         if (bif.req1_ready) begin
            rdy1_cnt++; acc1 = 1'b1;
            if (first_r1 < 0) first_r1 = wr_data.size();
         end
         if (!bif.m_valid || rsp_hold) begin
            bif.m_ready = 1'b0; wcnt = 0;
         end else if (wcnt >= wait_cycles) begin
            bif.m_ready = 1'b1;
            wr_addr.push_back(bif.m_addr);
            wr_data.push_back(bif.m_wdata);
            wr_strb.push_back(bif.m_wstrb);
            wr_grant.push_back(bif.grant);
         end else begin
            bif.m_ready = 1'b0; wcnt++;
         end
         prev_hs   = bif.m_ready;
         prev_pend = bif.m_valid && !bif.m_ready;
         sv_addr = bif.m_addr; sv_data = bif.m_wdata; sv_strb = bif.m_wstrb;
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic clear_log();
      wr_addr.delete(); wr_data.delete(); wr_strb.delete(); wr_grant.delete();
      rdy0_cnt = 0; rdy1_cnt = 0; first_r1 = -1;
   endtask

   task automatic wait_writes(input int n, input int budget, input string tag);
      int k = 0;
      while (wr_data.size() < n && k < budget) begin step(1); k++; end
      check({tag, "_wr_count"}, 32'(wr_data.size()), 32'(n));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q0.delete(); q1.delete(); acc0 = 1'b0; acc1 = 1'b0;
      step(2);
      clear_log();
      reset = 1'b0;
      wait_writes(1, 20, "rst_cfg");
      step(2);
      clear_log();
   endtask

   logic [31:0] exp_t2 [2] = '{32'h48, 32'h69};
   logic [31:0] exp_t3 [4] = '{32'h31, 32'h32, 32'h33, 32'h41};
   logic [31:0] exp_t4 [8] = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23};

   initial begin
      reset = 1'b1;
      step(3);
      // reset values
      check("rst_m_valid", 32'(bif.m_valid), 32'd0);
      check("rst_m_addr",  bif.m_addr, 32'h0);
      check("rst_m_wdata", bif.m_wdata, 32'h0);
      check("rst_m_wstrb", 32'(bif.m_wstrb), 32'h0);
      check("rst_grant",   32'(bif.grant), 32'h0);
      check("rst_busy",    32'(bif.busy), 32'd1);
      check("rst_ready0",  32'(bif.req0_ready), 32'd0);

      // divider programming
      reset = 1'b0;
      wait_writes(1, 20, "cfg");
      check("cfg_addr",  wr_addr[0], BASE);
      check("cfg_strb",  32'(wr_strb[0]), 32'hF);
      check("cfg_wdata", wr_data[0], 32'd104);
      step(3);
      check("cfg_busy_after",  32'(bif.busy), 32'd0);
      check("cfg_grant_after", 32'(bif.grant), 32'd0);
      check("cfg_single",      32'(wr_data.size()), 32'd1);

      // two-byte packet with a slow UART
      clear_log();
      wait_cycles = 5;
      q0.push_back({1'b0, 8'h48});
      q0.push_back({1'b1, 8'h69});
      wait_writes(2, 100, "t2");
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t2_addr%0d", i), wr_addr[i], BASE + 32'd4);
         check($sformatf("t2_data%0d", i), wr_data[i], exp_t2[i]);
         check($sformatf("t2_strb%0d", i), 32'(wr_strb[i]), 32'h1);
         check($sformatf("t2_grant%0d", i), 32'(wr_grant[i]), 32'h1);
      end
      step(2);
      check("t2_ready0_pulses", 32'(rdy0_cnt), 32'd2);
      check("t2_grant_end", 32'(bif.grant), 32'd0);

      // simultaneous arrival: locked 3-byte packet from req0 first
      do_reset();
      wait_cycles = 1;
      q0.push_back({1'b0, 8'h31});
      q0.push_back({1'b0, 8'h32});
      q0.push_back({1'b1, 8'h33});
      q1.push_back({1'b1, 8'h41});
      wait_writes(4, 100, "t3");
      for (int i = 0; i < 4; i++)
         check($sformatf("t3_data%0d", i), wr_data[i], exp_t3[i]);
      check("t3_ready1_first", 32'(first_r1), 32'd3);
      check("t3_ready1_pulses", 32'(rdy1_cnt), 32'd1);

      // both always valid, single-byte packets alternate
      do_reset();
      wait_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         q0.push_back({1'b1, 8'(8'h10 + i)});
         q1.push_back({1'b1, 8'(8'h20 + i)});
      end
      wait_writes(8, 100, "t4");
      for (int i = 0; i < 8; i++)
         check($sformatf("t4_data%0d", i), wr_data[i], exp_t4[i]);
      check("t4_grant1", 32'(wr_grant[1]), 32'h2);

      // reset during a stalled write
      do_reset();
      rsp_hold = 1'b1;
      q0.push_back({1'b1, 8'h5A});
      begin
         int k = 0;
         while (!bif.m_valid && k < 20) begin step(1); k++; end
      end
      check("t5_write_seen", 32'(bif.m_valid), 32'd1);
      step(1);
      reset = 1'b1;
      step(1);
      check("t5_m_valid_drop", 32'(bif.m_valid), 32'd0);
      check("t5_grant", 32'(bif.grant), 32'd0);
      check("t5_busy",  32'(bif.busy), 32'd1);
      clear_log();
      rsp_hold = 1'b0;
      reset = 1'b0;
      wait_writes(1, 20, "t5_cfg");
      check("t5_cfg_addr",  wr_addr[0], BASE);
      check("t5_cfg_wdata", wr_data[0], 32'd104);
      step(8);
      check("t5_no_data_write", 32'(wr_data.size()), 32'd1);

      // owner stalls mid-packet
      do_reset();
      q0.push_back({1'b0, 8'h55});
      wait_writes(1, 20, "t6_first");
      q1.push_back({1'b1, 8'h77});
`ifdef UART_TX_ARB_TIMEOUT_EN
      wait_writes(2, 60, "t6_timeout");
      check("t6_data1",  wr_data[1], 32'h77);
      check("t6_grant1", 32'(wr_grant[1]), 32'h2);
`else
      step(60);
      check("t6_locked_writes", 32'(wr_data.size()), 32'd1);
      check("t6_grant_held",    32'(bif.grant), 32'h1);
      check("t6_ready1_never",  32'(rdy1_cnt), 32'd0);
`endif

      check("bus_stable_err", 32'(stab_err), 32'd0);
      check("bus_gap_err",    32'(gap_err), 32'd0);
      check("ready_onehot",   32'(both_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Bus master that shares the UART peripheral's transmit path between two byte-stream requesters, e.g. the CPU console path and a hardware trace/logger.
- After reset it programs the baud divider once. It then converts granted bytes into single-byte writes to the UART data register.
- Arbitration is round-robin with packet lock: a granted requester keeps the UART until it sends a byte flagged last, so lines from the two sources do not interleave.

Parameters:
- CLK_DIV, 32'd104: value written to the divider register after reset (12 MHz / 115200).
- BASE_ADDR, 32'h0200_0000: UART base. Divider register is at BASE_ADDR+0; data register is at BASE_ADDR+4.
- LOCK_TIMEOUT, 16'd1000: idle cycles before a lock is forcibly released. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a byte
- req0_ready  out  1  requester 0 byte accepted this cycle
- req0_data  in  8  requester 0 byte
- req0_last  in  1  byte ends requester 0's packet
- req1_valid  in  1  requester 1 has a byte
- req1_ready  out  1  requester 1 byte accepted this cycle
- req1_data  in  8  requester 1 byte
- req1_last  in  1  byte ends requester 1's packet
- m_valid  out  1  UART bus request
- m_ready  in  1  UART bus completion (held low while the transmitter is busy)
- m_wstrb  out  4  byte write strobes
- m_addr  out  32  bus address
- m_wdata  out  32  bus write data
- grant  out  2  one-hot current owner; 0 when unowned
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state=CFG, m_valid=0, m_wstrb=0, m_addr=0, m_wdata=0, grant=0, lock=0, rr_ptr=0, req*_ready=0.
- m_* outputs are registered. Once m_valid is high, m_addr, m_wdata and m_wstrb are held stable until the edge where m_valid&&m_ready; m_valid falls at that edge.
- Consecutive bus requests are always separated by at least one cycle with m_valid=0.
- CFG state:
  - First edge after reset deasserts: m_valid<=1, m_addr<=BASE_ADDR, m_wstrb<=4'hF, m_wdata<=CLK_DIV.
  - On m_valid&&m_ready, go to IDLE.
  - No requester is accepted in CFG.
- IDLE state: candidate selection:
  - Lock set: the candidate is the locked owner only.
  - Lock clear, both valid: the candidate is rr_ptr.
  - Lock clear, one valid: the candidate is that requester.
- IDLE state: accepting a byte:
  - req*_ready is combinational: reqN_ready = (state==IDLE) && (candidate==N) && reqN_valid. At most one ready is high per cycle.
  - On acceptance: latch data and last; grant<=owner; lock<=!last; m_valid<=1, m_addr<=BASE_ADDR+4, m_wstrb<=4'b0001, m_wdata<={24'h0,data}; go to WRITE.
- WRITE state:
  - Wait for m_ready; any number of wait cycles is legal.
  - On m_valid&&m_ready with last latched: lock<=0, grant<=0, rr_ptr<=other requester.
  - On m_valid&&m_ready without last: grant is kept.
  - In both cases, go to IDLE.
- Throughput: at most one byte per 2 cycles (IDLE + WRITE with immediate m_ready).
- Lock semantics: the non-owner's valid byte waits, with ready low, until the owner's last byte completes.
- Packet boundaries: a single byte with last=1 is a complete packet. req*_last is sampled only when the byte is accepted.
- Reset mid-operation: an in-flight bus request is abandoned (m_valid=0 the following cycle). All state returns to reset values and the divider is reprogrammed after reset releases.
- Simultaneous arrival after a packet ends: the other requester wins (rr_ptr was updated in WRITE).

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter increments each IDLE cycle in which lock=1 and the owner's valid=0. It clears whenever a byte is accepted.
  - When the counter reaches LOCK_TIMEOUT: lock<=0, grant<=0, rr_ptr<=other requester, counter<=0. This takes effect in the same cycle; no byte is accepted in that cycle.
- Disabled: no counter. A lock persists until the owner's last byte completes, however long the owner stalls.

Test Plan:
- Reset release, m_ready tied 1 -> exactly one write with addr 0x0200_0000, wstrb 4'hF, wdata 104; then busy=0 and grant=0.
- req0 sends 0x48, 0x69 (last on 0x69), m_ready held 0 for 5 cycles per byte -> two writes to 0x0200_0004 with wdata 0x48 then 0x69, wstrb 4'b0001; req0_ready pulses once per byte.
- req0 packet of 3 bytes and req1 single byte (0x41, last) asserted in the same cycle -> req0's 3 bytes are written first (rr_ptr=0), then 0x41; req1_ready stays 0 until req0's last write completes.
- Both requesters continuously valid, every byte last -> written sources alternate 0,1,0,1.
- Reset asserted 1 cycle into a WRITE with m_ready=0 -> m_valid=0 the next cycle; after release the divider write repeats before any data write.
- With UART_TX_ARB_TIMEOUT_EN and LOCK_TIMEOUT=8: req0 sends a byte without last, then drops valid; req1 valid -> lock released after 8 idle cycles and req1's byte is written. Without the macro, req1 is never served.
